// File: rtl/rv32i_pkg.sv
// Shared definitions for the single-cycle RV32I core: opcode constants,
// ALU operation and immediate-format enums, branch funct3 codes, the
// decoded control bundle and the funct3/funct7 -> ALU op helper.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  typedef struct packed {
    logic     reg_we;
    logic     mem_we;
    logic     branch;
    logic     jal;
    logic     jalr;
    logic     alu_a_pc;   // operand A = PC (AUIPC)
    logic     alu_b_imm;  // operand B = immediate
    alu_op_e  alu_op;
    imm_sel_e imm_sel;
    wb_sel_e  wb_sel;
  } ctrl_t;

  // funct7[5] selects SUB only for register-register ops; for shifts it
  // selects arithmetic right shift in both R and I forms.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                         input logic is_reg);
    case (f3)
      3'd0:    return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return f7b5 ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_if.sv
// Data-memory bus between the core datapath (master) and data_mem (slave).
//   addr  : byte address (word index taken from addr[AW+1:2])
//   wdata : store data
//   we    : write strobe, sampled on the rising clock edge
//   rdata : combinational read data
interface rv32i_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;

  modport master (output addr, wdata, we, input rdata);
  modport slave  (input addr, wdata, we, output rdata);
endinterface

// File: rtl/rv32i_processor_units.sv
// Combinational units and storage of the RV32I core.
//   alu      : op, a, b -> y
//   imm_gen  : instr[31:7], sel -> sign-extended immediate
//   control  : opcode/funct3/funct7[5] -> ctrl_t bundle
//   inst_mem : combinational word fetch by PC; optional load port
//   reg_file : 2 comb read ports, 1 write port on clk; x0 hardwired to 0
//   data_mem : word memory behind rv32i_if.slave, write on clk
// None of the storage is reset so preloaded contents survive rst.

module alu
  import rv32i_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << b[4:0];
      ALU_SLT:    y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {31'b0, a < b};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> b[4:0];
      ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end
endmodule

module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_sel_e    sel,
  output logic [31:0] imm
);
  always_comb begin
    imm = '0;
    case (sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
endmodule

module control
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output ctrl_t      ctrl
);
  // Unknown opcodes fall through with every write strobe low: a NOP.
  always_comb begin
    ctrl         = '0;
    ctrl.alu_op  = ALU_ADD;
    ctrl.imm_sel = IMM_I;
    ctrl.wb_sel  = WB_ALU;
    case (opcode)
      OPC_OP: begin
        ctrl.reg_we = 1'b1;
        ctrl.alu_op = alu_decode(funct3, funct7_b5, 1'b1);
      end
      OPC_OP_IMM: begin
        ctrl.reg_we    = 1'b1;
        ctrl.alu_b_imm = 1'b1;
        ctrl.alu_op    = alu_decode(funct3, funct7_b5, 1'b0);
      end
      OPC_LOAD: begin
        ctrl.reg_we    = 1'b1;
        ctrl.alu_b_imm = 1'b1;
        ctrl.wb_sel    = WB_MEM;
      end
      OPC_STORE: begin
        ctrl.mem_we    = 1'b1;
        ctrl.alu_b_imm = 1'b1;
        ctrl.imm_sel   = IMM_S;
      end
      OPC_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.imm_sel = IMM_B;
      end
      OPC_JAL: begin
        ctrl.reg_we  = 1'b1;
        ctrl.jal     = 1'b1;
        ctrl.imm_sel = IMM_J;
        ctrl.wb_sel  = WB_PC4;
      end
      OPC_JALR: begin
        ctrl.reg_we    = 1'b1;
        ctrl.jalr      = 1'b1;
        ctrl.alu_b_imm = 1'b1;
        ctrl.wb_sel    = WB_PC4;
      end
      OPC_LUI: begin
        ctrl.reg_we    = 1'b1;
        ctrl.alu_b_imm = 1'b1;
        ctrl.imm_sel   = IMM_U;
        ctrl.alu_op    = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        ctrl.reg_we    = 1'b1;
        ctrl.alu_a_pc  = 1'b1;
        ctrl.alu_b_imm = 1'b1;
        ctrl.imm_sel   = IMM_U;
      end
      default: ;
    endcase
  end
endmodule

module inst_mem #(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic [31:0]   addr,
  output logic [31:0]   instr
);
  logic [31:0] mem [DEPTH];
  logic        unused_ok;

  // PC[1:0] and bits above the index are dropped: out-of-range wraps.
  assign instr     = mem[addr[AW+1:2]];
  assign unused_ok = &{1'b0, addr[31:AW+2], addr[1:0]};

  always_ff @(posedge clk)
    if (load_en) mem[load_addr] <= load_data;
endmodule

module reg_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] reg_mem [32];

  assign rd1 = (rs1 == 5'd0) ? '0 : reg_mem[rs1];
  assign rd2 = (rs2 == 5'd0) ? '0 : reg_mem[rs2];

  always_ff @(posedge clk)
    if (we && rd != 5'd0) reg_mem[rd] <= wd;
endmodule

module data_mem #(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input logic   clk,
  rv32i_if.slave bus
);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          unused_ok;

  assign idx       = bus.addr[AW+1:2];
  assign bus.rdata = mem[idx];
  assign unused_ok = &{1'b0, bus.addr[31:AW+2], bus.addr[1:0]};

  always_ff @(posedge clk)
    if (bus.we) mem[idx] <= bus.wdata;
endmodule

// File: rtl/rv32i_processor.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and writeback
// all complete within one clock; state commits on the rising edge.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset; forces PC=0 and blocks all
//         register/memory writes while asserted
// Optional: define PROCESSOR_TRACE_EN to print one trace line per retired
// instruction (PC, instruction, rd/value or store address/data).
module rv32i_processor
  import rv32i_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input logic clk,
  input logic rst
);
  logic [31:0] pc, pc_next, pc_plus4, pc_imm;
  logic [31:0] instr, imm, rs1_val, rs2_val;
  logic [31:0] alu_a, alu_b, alu_y, wb_data;
  logic        br_taken, rf_we;
  ctrl_t       ctrl;

  rv32i_if dbus ();

  inst_mem #(.DEPTH(IMEM_DEPTH)) inst_mem_i (
    .clk(clk), .load_en(1'b0), .load_addr('0), .load_data('0),
    .addr(pc), .instr(instr)
  );

  control control_i (
    .opcode(instr[6:0]), .funct3(instr[14:12]), .funct7_b5(instr[30]), .ctrl(ctrl)
  );

  imm_gen imm_gen_i (.instr(instr[31:7]), .sel(ctrl.imm_sel), .imm(imm));

  reg_file reg_file_i (
    .clk(clk), .we(rf_we), .rs1(instr[19:15]), .rs2(instr[24:20]),
    .rd(instr[11:7]), .wd(wb_data), .rd1(rs1_val), .rd2(rs2_val)
  );

  assign alu_a = ctrl.alu_a_pc  ? pc  : rs1_val;
  assign alu_b = ctrl.alu_b_imm ? imm : rs2_val;

  alu alu_i (.op(ctrl.alu_op), .a(alu_a), .b(alu_b), .y(alu_y));

  // Load/store address is always rs1+imm from the ALU.
  assign dbus.addr  = alu_y;
  assign dbus.wdata = rs2_val;
  assign dbus.we    = ctrl.mem_we & ~rst;

  data_mem #(.DEPTH(DMEM_DEPTH)) data_mem_i (.clk(clk), .bus(dbus));

  always_comb begin
    case (instr[14:12])
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val <  rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;
  assign pc_imm   = pc + imm;

  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.jalr)                                 pc_next = alu_y & ~32'd1;
    else if (ctrl.jal || (ctrl.branch && br_taken)) pc_next = pc_imm;
  end

  always_comb begin
    case (ctrl.wb_sel)
      WB_MEM:  wb_data = dbus.rdata;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_y;
    endcase
  end

  assign rf_we = ctrl.reg_we & ~rst;

  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= '0;
    else     pc <= pc_next;

`ifdef PROCESSOR_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (dbus.we)
        $display("trace pc=%h instr=%h store [%h]=%h", pc, instr, dbus.addr, dbus.wdata);
      else if (rf_we)
        $display("trace pc=%h instr=%h x%0d=%h", pc, instr, instr[11:7], wb_data);
      else
        $display("trace pc=%h instr=%h", pc, instr);
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_processor.sv
// Directed bench for rv32i_processor: preloads memories hierarchically,
// steps the core one edge at a time and checks PC, registers and memory
// against hand-computed values.
module tb_rv32i_processor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  localparam int OP_IMM = 'h13, LOAD = 'h03, LUI = 'h37, AUIPC = 'h17, JALR = 'h67;

  rv32i_processor #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                        input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input int imm, input int rd, input int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  initial begin
    // ---- reset and first R-type ----
    for (int i = 0; i < 64; i++) dut.inst_mem_i.mem[i] = 32'h0;
    for (int i = 0; i < 32; i++) dut.reg_file_i.reg_mem[i] = 32'h0;
    dut.reg_file_i.reg_mem[2] = 32'd5;
    dut.reg_file_i.reg_mem[4] = 32'd7;
    dut.inst_mem_i.mem[0]     = 32'h002201B3;  // add x3,x4,x2
    @(posedge clk); #2;
    chk("reset_pc",        dut.pc, 32'h0);
    chk("reset_fetch",     dut.instr, 32'h002201B3);
    chk("reset_keeps_x2",  dut.reg_file_i.reg_mem[2], 32'd5);
    chk("reset_no_write",  dut.reg_file_i.reg_mem[3], 32'd0);
    @(negedge clk); rst = 1'b0;
    step();
    chk("add_x3",  dut.reg_file_i.reg_mem[3], 32'd12);
    chk("add_pc",  dut.pc, 32'd4);

    // ---- ALU / memory / upper immediates ----
    @(negedge clk); rst = 1'b1;
    dut.reg_file_i.reg_mem[0]  = 32'h0;
    dut.reg_file_i.reg_mem[1]  = 32'h100;
    dut.reg_file_i.reg_mem[2]  = 32'hDEADBEEF;
    dut.reg_file_i.reg_mem[8]  = 32'h80000000;
    dut.reg_file_i.reg_mem[9]  = 32'hFFFF;
    dut.reg_file_i.reg_mem[13] = 32'h77;
    dut.reg_file_i.reg_mem[31] = 32'hA5;
    dut.data_mem_i.mem[65]     = 32'h0;
    dut.inst_mem_i.mem[0]  = enc_i(5, 0, 0, 0, OP_IMM);       // addi x0,x0,5
    dut.inst_mem_i.mem[1]  = enc_r(0, 0, 0, 0, 9);            // add x9,x0,x0
    dut.inst_mem_i.mem[2]  = enc_u(1, 7, AUIPC);              // auipc x7,1
    dut.inst_mem_i.mem[3]  = enc_s(4, 2, 1);                  // sw x2,4(x1)
    dut.inst_mem_i.mem[4]  = enc_i(4, 1, 2, 5, LOAD);         // lw x5,4(x1)
    dut.inst_mem_i.mem[5]  = enc_u('h12345, 6, LUI);          // lui x6,0x12345
    dut.inst_mem_i.mem[6]  = enc_i('h404, 8, 5, 10, OP_IMM);  // srai x10,x8,4
    dut.inst_mem_i.mem[7]  = enc_r('h20, 2, 1, 0, 11);        // sub x11,x1,x2
    dut.inst_mem_i.mem[8]  = enc_r(0, 2, 1, 3, 12);           // sltu x12,x1,x2
    dut.inst_mem_i.mem[9]  = enc_r(0, 2, 1, 2, 13);           // slt x13,x1,x2
    dut.inst_mem_i.mem[10] = enc_i(4, 1, 1, 14, OP_IMM);      // slli x14,x1,4
    dut.inst_mem_i.mem[11] = enc_i(-1, 1, 4, 16, OP_IMM);     // xori x16,x1,-1
    dut.inst_mem_i.mem[12] = 32'hFFFFFFFF;                    // unknown opcode
    @(negedge clk); rst = 1'b0;
    step(); chk("x0_write_discarded", dut.reg_file_i.reg_mem[0], 32'h0);
    step(); chk("add_x0_x0",  dut.reg_file_i.reg_mem[9], 32'h0);
    step(); chk("auipc",      dut.reg_file_i.reg_mem[7], 32'h1008);
    step(); chk("sw_dmem65",  dut.data_mem_i.mem[65], 32'hDEADBEEF);
    step(); chk("lw_x5",      dut.reg_file_i.reg_mem[5], 32'hDEADBEEF);
    step(); chk("lui",        dut.reg_file_i.reg_mem[6], 32'h12345000);
    step(); chk("srai",       dut.reg_file_i.reg_mem[10], 32'hF8000000);
    step(); chk("sub_wrap",   dut.reg_file_i.reg_mem[11], 32'h21524211);
    step(); chk("sltu",       dut.reg_file_i.reg_mem[12], 32'h1);
    step(); chk("slt_signed", dut.reg_file_i.reg_mem[13], 32'h0);
    step(); chk("slli",       dut.reg_file_i.reg_mem[14], 32'h1000);
    step(); chk("xori_m1",    dut.reg_file_i.reg_mem[16], 32'hFFFFFEFF);
    step(); chk("nop_pc",     dut.pc, 32'd52);
            chk("nop_no_wr",  dut.reg_file_i.reg_mem[31], 32'hA5);

    // ---- branches and jumps: PC 0->4->44->48->8->16->20->4->8 ----
    @(negedge clk); rst = 1'b1;
    dut.reg_file_i.reg_mem[1]  = 32'hFFFFFFFF;
    dut.reg_file_i.reg_mem[2]  = 32'd1;
    dut.reg_file_i.reg_mem[3]  = 32'd5;
    dut.reg_file_i.reg_mem[4]  = 32'd5;
    dut.reg_file_i.reg_mem[5]  = 32'h0;
    dut.reg_file_i.reg_mem[20] = 32'h0;
    for (int i = 0; i < 16; i++) dut.inst_mem_i.mem[i] = 32'h0;
    dut.inst_mem_i.mem[0]  = enc_b(100, 4, 3, 1);            // bne x3,x4,+100
    dut.inst_mem_i.mem[1]  = enc_b(40, 2, 1, 4);             // blt x1,x2,+40
    dut.inst_mem_i.mem[2]  = enc_b(8, 1, 1, 0);              // beq x1,x1,+8
    dut.inst_mem_i.mem[3]  = enc_i(1, 0, 0, 20, OP_IMM);     // addi x20,x0,1 (skipped)
    dut.inst_mem_i.mem[4]  = enc_b(100, 1, 2, 7);            // bgeu x2,x1,+100
    dut.inst_mem_i.mem[5]  = enc_j(-16, 1);                  // jal x1,-16
    dut.inst_mem_i.mem[11] = enc_b(40, 2, 1, 6);             // bltu x1,x2,+40
    dut.inst_mem_i.mem[12] = enc_i(3, 3, 0, 5, JALR);        // jalr x5,3(x3)
    @(negedge clk); rst = 1'b0;
    step(); chk("bne_equal_not_taken", dut.pc, 32'd4);
    step(); chk("blt_signed_taken",    dut.pc, 32'd44);
    step(); chk("bltu_not_taken",      dut.pc, 32'd48);
    step(); chk("jalr_target",         dut.pc, 32'd8);
            chk("jalr_link",           dut.reg_file_i.reg_mem[5], 32'd52);
    step(); chk("beq_taken",           dut.pc, 32'd16);
    step(); chk("bgeu_not_taken",      dut.pc, 32'd20);
    step(); chk("jal_back",            dut.pc, 32'd4);
            chk("jal_link",            dut.reg_file_i.reg_mem[1], 32'd24);
    step(); chk("blt_not_taken",       dut.pc, 32'd8);
            chk("skipped_instr",       dut.reg_file_i.reg_mem[20], 32'h0);

    // ---- asynchronous reset mid-run suppresses the coinciding write ----
    dut.inst_mem_i.mem[0]      = enc_i(77, 0, 0, 21, OP_IMM); // addi x21,x0,77
    dut.reg_file_i.reg_mem[21] = 32'h1234;
    #2 rst = 1'b1;
    #1 chk("async_reset_pc", dut.pc, 32'h0);
    @(posedge clk); #1;
    chk("reset_edge_no_write", dut.reg_file_i.reg_mem[21], 32'h1234);
    chk("reset_edge_pc",       dut.pc, 32'h0);
    @(negedge clk); rst = 1'b0;
    step();
    chk("post_reset_addi", dut.reg_file_i.reg_mem[21], 32'd77);
    chk("post_reset_pc",   dut.pc, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
